// File: rtl/op_phase_sequencer_if.sv
// Fetch-side opcode handshake between the fetch unit and op_phase_sequencer.
//
// Handshake: a byte moves when op_valid && op_ready are both high on a rising
// CLK edge. The fetch unit holds op_valid/op_data stable until that edge.
// op_ready does not depend on op_valid in the same cycle.
//
// master: fetch unit (drives op_valid/op_data).
// slave : sequencer (drives op_ready).
interface op_phase_sequencer_if #(
    parameter int OP_W = 8
);
    logic            op_valid;
    logic [OP_W-1:0] op_data;
    logic            op_ready;

    modport master (
        output op_valid,
        output op_data,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_data,
        output op_ready
    );
endinterface

// File: rtl/op_phase_sequencer.sv
// Opcode/phase sequencer feeding the top-level opcode decoder tree.
//
// Latches opcode bytes from the fetch unit into Source, runs the execution
// phase counter XPT, and returns to FETCH when the decoders raise
// PR_Reset_XPT (or restarts the same opcode when Pa_Ophd is also high).
// True and complement forms of XPT and Source are presented to the decoders.
//
// Optional build macro: OP_PHASE_SEQ_WATCHDOG_EN
//   When defined, adds output xpt_fault. An XPT advance past its maximum in
//   EXEC aborts the instruction back to FETCH and pulses xpt_fault for one
//   cycle. When undefined, XPT wraps to 0 silently and execution continues.
//
// state_dbg exposes the FSM state: 0 = FETCH, 1 = EXEC, 2 = HOLD.
module op_phase_sequencer #(
    parameter int              XPT_W        = 5,
    parameter int              OP_W         = 8,
    parameter logic [OP_W-1:0] RESET_OPCODE = 8'h00
) (
    input  logic                CLK,
    input  logic                notReset,
    op_phase_sequencer_if.slave fetch,
    input  logic                stall,
    input  logic                PR_Reset_XPT,
    input  logic                Pa_Ophd,
    output logic                enable,
    output logic [XPT_W-1:0]    XPT,
    output logic [XPT_W-1:0]    notXPT,
    output logic [OP_W-1:0]     Source,
    output logic [OP_W-1:0]     notSource,
    output logic                busy,
`ifdef OP_PHASE_SEQ_WATCHDOG_EN
    output logic                xpt_fault,
`endif
    output logic [1:0]          state_dbg
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [XPT_W-1:0] XPT_MAX = {XPT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [XPT_W-1:0] xpt_q, xpt_d;
    logic [OP_W-1:0]  src_q, src_d;
    logic             op_ready;
    logic             accept;
    logic             fault_d;

    // Handshake and decoder enables are pure functions of the state register.
    always_comb begin
        op_ready = (state_q == ST_FETCH);
        enable   = (state_q == ST_EXEC);
        busy     = (state_q != ST_FETCH);
        accept   = fetch.op_valid && op_ready;
    end

    assign fetch.op_ready = op_ready;

    // Complements come straight off the registers so decoders see both rails
    // in the same cycle.
    always_comb begin
        XPT       = xpt_q;
        notXPT    = ~xpt_q;
        Source    = src_q;
        notSource = ~src_q;
        state_dbg = state_q;
    end

    // Next-state, phase counter and opcode latch decisions.
    always_comb begin
        state_d = state_q;
        xpt_d   = xpt_q;
        src_d   = src_q;
        fault_d = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // Completion inputs have no meaning while fetching.
                if (accept) begin
                    src_d   = fetch.op_data;
                    xpt_d   = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (PR_Reset_XPT) begin
                    // Completion wins over stall; Pa_Ophd replays Source.
                    xpt_d = '0;
                    if (!Pa_Ophd) begin
                        state_d = ST_FETCH;
                    end
                end else if (stall) begin
                    // Freeze the phase; HOLD resumes from the same XPT.
                    state_d = ST_HOLD;
                end else begin
`ifdef OP_PHASE_SEQ_WATCHDOG_EN
                    if (xpt_q == XPT_MAX) begin
                        xpt_d   = '0;
                        state_d = ST_FETCH;
                        fault_d = 1'b1;
                    end else begin
                        xpt_d = xpt_q + XPT_W'(1);
                    end
`else
                    // Wraps from XPT_MAX to 0 and keeps executing.
                    xpt_d = xpt_q + XPT_W'(1);
`endif
                end
            end
            ST_HOLD: begin
                // Return to EXEC without advancing so no phase is skipped.
                if (!stall) begin
                    state_d = ST_EXEC;
                end
            end
            default: begin
                state_d = ST_FETCH;
                xpt_d   = '0;
            end
        endcase
    end

    // State, phase and opcode registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge notReset) begin
        if (!notReset) begin
            state_q <= ST_FETCH;
            xpt_q   <= '0;
            src_q   <= RESET_OPCODE;
        end else begin
            state_q <= state_d;
            xpt_q   <= xpt_d;
            src_q   <= src_d;
        end
    end

`ifdef OP_PHASE_SEQ_WATCHDOG_EN
    logic fault_q;

    // One-cycle fault pulse, coincident with the forced return to FETCH.
    always_ff @(posedge CLK or negedge notReset) begin
        if (!notReset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign xpt_fault = fault_q;
`else
    logic unused_fault;
    assign unused_fault = fault_d ^ (XPT_MAX == '0);
`endif

endmodule

// File: tb/tb_op_phase_sequencer.sv
// Directed testbench for op_phase_sequencer. Inputs change 1 ns after the
// rising edge and outputs are checked at the same point.
module tb_op_phase_sequencer;

    localparam int XPT_W = 5;
    localparam int OP_W  = 8;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic notReset = 1'b0;
    always #5 CLK = ~CLK;

    logic             stall;
    logic             PR_Reset_XPT;
    logic             Pa_Ophd;
    logic             enable;
    logic [XPT_W-1:0] XPT;
    logic [XPT_W-1:0] notXPT;
    logic [OP_W-1:0]  Source;
    logic [OP_W-1:0]  notSource;
    logic             busy;
    logic [1:0]       state_dbg;
`ifdef OP_PHASE_SEQ_WATCHDOG_EN
    logic             xpt_fault;
`endif

    op_phase_sequencer_if #(.OP_W(OP_W)) fetch_if ();

    op_phase_sequencer #(
        .XPT_W        (XPT_W),
        .OP_W         (OP_W),
        .RESET_OPCODE (8'h00)
    ) dut (
        .CLK          (CLK),
        .notReset     (notReset),
        .fetch        (fetch_if),
        .stall        (stall),
        .PR_Reset_XPT (PR_Reset_XPT),
        .Pa_Ophd      (Pa_Ophd),
        .enable       (enable),
        .XPT          (XPT),
        .notXPT       (notXPT),
        .Source       (Source),
        .notSource    (notSource),
        .busy         (busy),
`ifdef OP_PHASE_SEQ_WATCHDOG_EN
        .xpt_fault    (xpt_fault),
`endif
        .state_dbg    (state_dbg)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Full output picture for one cycle; complements are computed here.
    task automatic check_all(input string tag, input logic [1:0] st,
                             input logic [XPT_W-1:0] exp_xpt, input logic [OP_W-1:0] exp_src);
        logic [XPT_W-1:0] nx;
        logic [OP_W-1:0]  ns;
        nx = ~exp_xpt;
        ns = ~exp_src;
        check_eq({tag, "_state"},     32'(state_dbg),        32'(st));
        check_eq({tag, "_xpt"},       32'(XPT),              32'(exp_xpt));
        check_eq({tag, "_notxpt"},    32'(notXPT),           32'(nx));
        check_eq({tag, "_source"},    32'(Source),           32'(exp_src));
        check_eq({tag, "_notsource"}, 32'(notSource),        32'(ns));
        check_eq({tag, "_enable"},    32'(enable),           32'(st == S_EXEC));
        check_eq({tag, "_op_ready"},  32'(fetch_if.op_ready), 32'(st == S_FETCH));
        check_eq({tag, "_busy"},      32'(busy),             32'(st != S_FETCH));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Offer one byte for one cycle; caller must be in FETCH.
    task automatic send_op(input logic [OP_W-1:0] b);
        fetch_if.op_valid = 1'b1;
        fetch_if.op_data  = b;
        step();
        fetch_if.op_valid = 1'b0;
        fetch_if.op_data  = '0;
    endtask

    // Advance n phases with no stall and no completion, checking each one.
    task automatic run_phases(input string tag, input int n, input logic [OP_W-1:0] src);
        for (int i = 1; i <= n; i++) begin
            step();
            check_all(tag, S_EXEC, XPT_W'(i), src);
        end
    endtask

    task automatic complete_op();
        PR_Reset_XPT = 1'b1;
        step();
        PR_Reset_XPT = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        fetch_if.op_valid = 1'b0;
        fetch_if.op_data  = '0;
        stall             = 1'b0;
        PR_Reset_XPT      = 1'b0;
        Pa_Ophd           = 1'b0;

        // Reset values
        #12;
        check_all("reset", S_FETCH, 5'd0, 8'h00);
`ifdef OP_PHASE_SEQ_WATCHDOG_EN
        check_eq("reset_fault", 32'(xpt_fault), 32'd0);
`endif
        step();
        notReset = 1'b1;
        step();

        // First opcode C7: EXEC with XPT=0 one cycle after the handshake
        send_op(8'hC7);
        check_all("c7_first", S_EXEC, 5'd0, 8'hC7);
        run_phases("c7_run", 3, 8'hC7);
        complete_op();
        check_all("c7_done", S_FETCH, 5'd0, 8'hC7);

        // Completion inputs ignored in FETCH
        PR_Reset_XPT = 1'b1;
        Pa_Ophd      = 1'b1;
        step();
        PR_Reset_XPT = 1'b0;
        Pa_Ophd      = 1'b0;
        check_all("fetch_ignore_pr", S_FETCH, 5'd0, 8'hC7);

        // Stall at XPT=2 for three cycles; PR ignored while in HOLD
        send_op(8'hA5);
        run_phases("a5_run", 2, 8'hA5);
        stall = 1'b1;
        step();
        check_all("hold1", S_HOLD, 5'd2, 8'hA5);
        PR_Reset_XPT = 1'b1;
        step();
        PR_Reset_XPT = 1'b0;
        check_all("hold2", S_HOLD, 5'd2, 8'hA5);
        step();
        check_all("hold3", S_HOLD, 5'd2, 8'hA5);
        stall = 1'b0;
        step();
        check_all("resume2", S_EXEC, 5'd2, 8'hA5);
        step();
        check_all("resume3", S_EXEC, 5'd3, 8'hA5);
        complete_op();
        check_all("a5_done", S_FETCH, 5'd0, 8'hA5);

        // Opcode hold on FF at XPT=4: restart without fetch
        send_op(8'hFF);
        run_phases("ff_run", 4, 8'hFF);
        Pa_Ophd = 1'b1;
        complete_op();
        Pa_Ophd = 1'b0;
        check_all("ff_replay", S_EXEC, 5'd0, 8'hFF);
        run_phases("ff_rerun", 1, 8'hFF);
        // Completion with stall high: stall ignored, back to FETCH
        stall = 1'b1;
        complete_op();
        stall = 1'b0;
        check_all("ff_done_stall", S_FETCH, 5'd0, 8'hFF);

        // Back-to-back: byte in the first FETCH cycle after completion
        send_op(8'h3C);
        check_all("b2b", S_EXEC, 5'd0, 8'h3C);
        // A byte offered during EXEC must not be latched
        fetch_if.op_valid = 1'b1;
        fetch_if.op_data  = 8'h99;
        step();
        fetch_if.op_valid = 1'b0;
        check_all("exec_no_latch", S_EXEC, 5'd1, 8'h3C);
        complete_op();

        // Reset asserted while in HOLD at XPT=5 with Source=CD
        send_op(8'hCD);
        run_phases("cd_run", 5, 8'hCD);
        stall = 1'b1;
        step();
        check_all("cd_hold", S_HOLD, 5'd5, 8'hCD);
        notReset          = 1'b0;
        fetch_if.op_valid = 1'b1;
        fetch_if.op_data  = 8'h77;
        #1;
        check_all("async_reset", S_FETCH, 5'd0, 8'h00);
        step();
        check_all("reset_drop", S_FETCH, 5'd0, 8'h00);
        fetch_if.op_valid = 1'b0;
        stall             = 1'b0;
        notReset          = 1'b1;
        step();
        check_all("post_reset", S_FETCH, 5'd0, 8'h00);

        // Phase counter end of range
        send_op(8'h5A);
        check_all("wrap_start", S_EXEC, 5'd0, 8'h5A);
        run_phases("wrap_run", 31, 8'h5A);
`ifdef OP_PHASE_SEQ_WATCHDOG_EN
        check_eq("wd_no_fault_yet", 32'(xpt_fault), 32'd0);
        step();
        check_all("wd_abort", S_FETCH, 5'd0, 8'h5A);
        check_eq("wd_fault_pulse", 32'(xpt_fault), 32'd1);
        step();
        check_eq("wd_fault_clear", 32'(xpt_fault), 32'd0);
        check_all("wd_idle", S_FETCH, 5'd0, 8'h5A);
`else
        step();
        check_all("wrap_zero", S_EXEC, 5'd0, 8'h5A);
        step();
        check_all("wrap_one", S_EXEC, 5'd1, 8'h5A);
        complete_op();
        check_all("wrap_done", S_FETCH, 5'd0, 8'h5A);
`endif

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_checks);
        $fatal(1);
    end

endmodule
